// File: rtl/scancode_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : scancode_decoder_if
// Description : Byte-in / key-event-out bundle between the PS/2 bit receiver,
//               the scan-code decoder and the keyboard-to-control logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface scancode_decoder_if;
  logic [7:0] din;        // received byte, valid only with din_new
  logic       din_new;    // 1-cycle strobe: new byte on din
  logic [8:0] key_code;   // {extended, code} of the last completed event
  logic       make;       // 1-cycle pulse: key pressed
  logic       brk;        // 1-cycle pulse: key released
  logic       seq_error;  // 1-cycle pulse: partial sequence aborted

  // Byte producer side (receiver / testbench)
  modport master (
    output din, din_new,
    input  key_code, make, brk, seq_error
  );

  // Decoder side
  modport slave (
    input  din, din_new,
    output key_code, make, brk, seq_error
  );
endinterface
`default_nettype wire

// File: rtl/scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : scancode_decoder
// Description : Assembles PS/2 Set-2 scan-code sequences (plain, E0, F0,
//               E0 F0) into single make/break key events with a 9-bit code.
//               Partial sequences are aborted on illegal bytes or when the
//               gap between bytes exceeds TIMEOUT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module scancode_decoder #(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int CNT_W          = 22
) (
  input  wire logic          clk,
  input  wire logic          resetN,
  scancode_decoder_if.slave  bus
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_EXT     = 2'd1;
  localparam logic [1:0] c_BRK     = 2'd2;
  localparam logic [1:0] c_EXT_BRK = 2'd3;

  localparam logic [CNT_W-1:0] c_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [8:0]       r_key_code;
  logic             r_make;
  logic             r_brk;
  logic             r_seq_error;
  logic [8:0]       w_key_code_nxt;
  logic             w_make_nxt;
  logic             w_brk_nxt;
  logic             w_seq_error_nxt;

  // Byte classification of the incoming byte
  logic w_is_e0;
  logic w_is_f0;
  logic w_is_disc;
  logic w_is_code;
  logic w_timeout;

  assign w_is_e0   = (bus.din == 8'hE0);
  assign w_is_f0   = (bus.din == 8'hF0);
  assign w_is_disc = (bus.din == 8'h00) || (bus.din == 8'hAA) ||
                     (bus.din == 8'hE1) || (bus.din == 8'hEE) ||
                     (bus.din == 8'hFA) || (bus.din == 8'hFE) ||
                     (bus.din == 8'hFF);
  assign w_is_code = !(w_is_e0 || w_is_f0 || w_is_disc);

  // A byte arriving on the terminal count wins over the timeout
  assign w_timeout = (r_state != c_IDLE) && !bus.din_new && (r_cnt == c_TERM);

  // State and registered outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= c_IDLE;
      r_key_code  <= 9'h000;
      r_make      <= 1'b0;
      r_brk       <= 1'b0;
      r_seq_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_key_code  <= w_key_code_nxt;
      r_make      <= w_make_nxt;
      r_brk       <= w_brk_nxt;
      r_seq_error <= w_seq_error_nxt;
    end
  end

  // Inter-byte gap counter: only runs while a sequence is pending
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_cnt <= '0;
    end else if (bus.din_new || (r_state == c_IDLE) || w_timeout) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_ONE;
    end
  end

  // Next-state decision on each received byte or on timeout
  always_comb begin
    w_state_nxt = r_state;
    if (bus.din_new) begin
      case (r_state)
        c_IDLE: begin
          if (w_is_e0)      w_state_nxt = c_EXT;
          else if (w_is_f0) w_state_nxt = c_BRK;
          else              w_state_nxt = c_IDLE;
        end
        c_EXT: begin
          if (w_is_f0)      w_state_nxt = c_EXT_BRK;
          else if (w_is_e0) w_state_nxt = c_EXT;
          else              w_state_nxt = c_IDLE;
        end
        default:            w_state_nxt = c_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nxt = c_IDLE;
    end
  end

  // Event pulses and key code for the completed or aborted sequence
  always_comb begin
    w_key_code_nxt  = r_key_code;
    w_make_nxt      = 1'b0;
    w_brk_nxt       = 1'b0;
    w_seq_error_nxt = 1'b0;
    if (bus.din_new) begin
      case (r_state)
        c_IDLE: begin
          if (w_is_code) begin
            w_make_nxt     = 1'b1;
            w_key_code_nxt = {1'b0, bus.din};
          end
        end
        c_EXT: begin
          if (w_is_code) begin
            w_make_nxt     = 1'b1;
            w_key_code_nxt = {1'b1, bus.din};
          end else if (w_is_disc) begin
            w_seq_error_nxt = 1'b1;
          end
        end
        c_BRK: begin
          if (w_is_code) begin
            w_brk_nxt      = 1'b1;
            w_key_code_nxt = {1'b0, bus.din};
          end else begin
            w_seq_error_nxt = 1'b1;
          end
        end
        default: begin
          if (w_is_code) begin
            w_brk_nxt      = 1'b1;
            w_key_code_nxt = {1'b1, bus.din};
          end else begin
            w_seq_error_nxt = 1'b1;
          end
        end
      endcase
    end else if (w_timeout) begin
      w_seq_error_nxt = 1'b1;
    end
  end

  assign bus.key_code  = r_key_code;
  assign bus.make      = r_make;
  assign bus.brk       = r_brk;
  assign bus.seq_error = r_seq_error;

endmodule
`default_nettype wire
